sdram_frame_wr_ctrl: RTL and testbench
======================================

# sdram_frame_wr_ctrl

Write-side frame sequencer between the bank ping-pong switch and the SDRAM controller. On each `wr_load` pulse it latches the write bank, rewinds the frame address, and then issues fixed-length burst write requests as soon as the camera write FIFO holds enough words. After the last word of the frame is committed it raises `frame_write_done`, which the bank switch uses to flip `wr_bank`.

## Interface
- `FRAME_WORDS`, 307200: words per frame (640x480 RGB565); must be ≥1 and < 2^ADDR_W.
- `BURST_LEN`, 256: full burst length in words; must be ≥1 and ≤ 2^LEN_W − 1.
- `ADDR_W`, 22: word address width within a bank.
- `LEN_W`, 9: burst-length field width.
- `USED_W`, 10: FIFO fill-level width.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sdram_init_done` in 1: SDRAM controller initialisation complete (level).
- `wr_load` in 1: one-cycle frame-restart pulse from the bank switch.
- `wr_bank` in 2: bank to write; sampled only when `wr_load` is applied.
- `fifo_usedw` in USED_W: words currently in the write FIFO.
- `wr_ack` in 1: controller accepted the request; one-cycle pulse.
- `wr_done` in 1: controller finished the accepted burst; one-cycle pulse.
- `wr_req` out 1: burst write request (level).
- `wr_ba` out 2: SDRAM bank for the request.
- `wr_addr` out ADDR_W: start word address of the request.
- `wr_len` out LEN_W: words in the request.
- `frame_write_done` out 1: high once the whole frame is written; cleared by the next applied `wr_load`.
- `frame_cnt` out 8: completed-frame counter; wraps 255→0.

## Operation
- States: IDLE, WAIT_DATA, REQ, BURST, DONE. Reset state is IDLE.
- Reset values: `wr_req`=0, `wr_ba`=0, `wr_addr`=0, `wr_len`=0, `frame_write_done`=0, `frame_cnt`=0. Internal `remaining`=0 and `load_pend`=0.
- Applying a load:
  - Sets `wr_ba`←`wr_bank`, `wr_addr`←0, `remaining`←FRAME_WORDS, `frame_write_done`←0, `load_pend`←0.
  - Next state is WAIT_DATA.
- IDLE: waits for `wr_load`, then applies the load.
- WAIT_DATA:
  - `need` = min(BURST_LEN, `remaining`).
  - If `sdram_init_done`=1 and `fifo_usedw` ≥ `need`, set `wr_len`←`need` and `wr_req`←1, then go to REQ.
- REQ:
  - `wr_req` is held high until `wr_ack`.
  - On `wr_ack`, `wr_req`←0 and the state goes to BURST.
- BURST: on `wr_done`:
  - `wr_addr`←`wr_addr`+`wr_len`, `remaining`←`remaining`−`wr_len`.
  - If the new `remaining` is 0, set `frame_write_done`←1, `frame_cnt`←`frame_cnt`+1 and go to DONE.
  - Otherwise go to WAIT_DATA.
- DONE: holds all outputs. A `wr_load` applies the load.
- `wr_load` in WAIT_DATA applies the load immediately.
- `wr_load` in REQ without `wr_ack`: `wr_req`←0 and the load is applied immediately. The request is withdrawn.
- `wr_load` coincident with `wr_ack` in REQ: the ack wins (go to BURST) and `load_pend`←1.
- `wr_load` in BURST: `load_pend`←1. An accepted burst is never aborted.
- On `wr_done` with `load_pend`=1:
  - The address and count update is performed.
  - If that completes the frame, `frame_cnt` still increments, but `frame_write_done` stays 0.
  - The pending load is then applied, so the next state is WAIT_DATA.
- `wr_load` coincident with `wr_done` in BURST: handled as the pending case above.
- `wr_ack` or `wr_done` arriving outside REQ or BURST respectively is ignored.
- Arithmetic: `wr_addr` and `remaining` are ADDR_W bits, unsigned, with no wrap. The parameter constraints guarantee no overflow.

## Timing
- `wr_req` rises on the same rising edge that samples the FIFO condition true in WAIT_DATA. There are no extra cycles of latency.
- `wr_ba`, `wr_addr` and `wr_len` are stable from the `wr_req` rise until the edge that samples `wr_done`.
- `wr_req` falls on the edge that samples `wr_ack`.
- Back-to-back bursts: after `wr_done`, the next `wr_req` rises no earlier than 2 edges later (BURST→WAIT_DATA→REQ).
- `frame_write_done` rises on the edge that samples the final `wr_done`. It falls on the edge that applies the next load.
- `wr_load` is registered externally on the falling edge, so it is stable at the rising edge; no synchroniser is required.
- Asserting `rst_n` low at any time returns all outputs to their reset values asynchronously. `wr_req` drops without a handshake.

## Test plan
- FRAME_WORDS=600, BURST_LEN=256, FIFO kept full, ack 1 cycle after `wr_req`, done 4 cycles after ack, `wr_bank`=2 at load → three bursts with (`wr_addr`,`wr_len`) = (0,256), (256,256), (512,88), all with `wr_ba`=2. Then `frame_write_done`=1 and `frame_cnt`=1.
- `sdram_init_done`=0 with a full FIFO → `wr_req` stays 0. It rises on the first edge after `sdram_init_done`=1.
- `fifo_usedw` ramps 0→255 → no request. At 256 → `wr_req` rises that edge. For the last 88-word burst, `fifo_usedw`=88 suffices.
- `wr_load` pulsed mid-BURST of the second burst → that burst completes, then the next request is (0,256) with the newly sampled `wr_ba`. `frame_write_done` never rises for the aborted frame.
- `wr_load` in REQ with no ack → `wr_req` drops on the next edge. A fresh request is issued from `wr_addr`=0.
- `rst_n` pulsed low during BURST → all outputs are 0 immediately. After release, the block idles until `wr_load`, and stray `wr_done` pulses are ignored.

Source files
------------

// File: rtl/sdram_frame_wr_ctrl.sv
// Write-side frame sequencer: turns a frame-restart pulse into a series
// of fixed-length SDRAM burst write requests paced by the camera FIFO.
module sdram_frame_wr_ctrl #(
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 256,
  parameter int ADDR_W      = 22,
  parameter int LEN_W       = 9,
  parameter int USED_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              wr_load,
  input  logic [1:0]        wr_bank,
  input  logic [USED_W-1:0] fifo_usedw,
  input  logic              wr_ack,
  input  logic              wr_done,
  output logic              wr_req,
  output logic [1:0]        wr_ba,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len,
  output logic              frame_write_done,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    REQ,
    BURST,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);

  state_t            state, state_n;
  logic [ADDR_W-1:0] remaining, remaining_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [ADDR_W-1:0] need, addr_sum, rem_diff;
  logic [LEN_W-1:0]  wr_len_n;
  logic [1:0]        wr_ba_n;
  logic [7:0]        frame_cnt_n;
  logic              wr_req_n, fwd_n;
  logic              load_pend, load_pend_n;
  logic              load_go, fifo_ok;

  assign need     = (remaining < BURST_A) ? remaining : BURST_A;
  assign addr_sum = wr_addr + ADDR_W'(wr_len);
  assign rem_diff = remaining - ADDR_W'(wr_len);
  assign fifo_ok  = sdram_init_done
                  && (ADDR_W'(fifo_usedw) >= need);

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    wr_addr_n   = wr_addr;
    wr_len_n    = wr_len;
    wr_ba_n     = wr_ba;
    wr_req_n    = wr_req;
    fwd_n       = frame_write_done;
    frame_cnt_n = frame_cnt;
    load_pend_n = load_pend;
    load_go     = 1'b0;

    unique case (state)
      IDLE: load_go = wr_load;
      WAIT_DATA: begin
        if (wr_load) begin
          load_go = 1'b1;
        end else if (fifo_ok) begin
          wr_len_n = LEN_W'(need);
          wr_req_n = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        // An accepted request always wins over a restart.
        if (wr_ack) begin
          wr_req_n = 1'b0;
          state_n  = BURST;
          if (wr_load) load_pend_n = 1'b1;
        end else if (wr_load) begin
          wr_req_n = 1'b0;
          load_go  = 1'b1;
        end
      end
      BURST: begin
        if (wr_done) begin
          wr_addr_n   = addr_sum;
          remaining_n = rem_diff;
          if (rem_diff == '0) frame_cnt_n = frame_cnt + 8'd1;
          if (load_pend || wr_load) begin
            load_go = 1'b1;
          end else if (rem_diff == '0) begin
            fwd_n   = 1'b1;
            state_n = DONE;
          end else begin
            state_n = WAIT_DATA;
          end
        end else if (wr_load) begin
          load_pend_n = 1'b1;
        end
      end
      DONE: load_go = wr_load;
      default: state_n = IDLE;
    endcase

    if (load_go) begin
      wr_ba_n     = wr_bank;
      wr_addr_n   = '0;
      remaining_n = FRAME_A;
      fwd_n       = 1'b0;
      load_pend_n = 1'b0;
      state_n     = WAIT_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      remaining        <= '0;
      wr_addr          <= '0;
      wr_len           <= '0;
      wr_ba            <= '0;
      wr_req           <= 1'b0;
      frame_write_done <= 1'b0;
      frame_cnt        <= '0;
      load_pend        <= 1'b0;
    end else begin
      state            <= state_n;
      remaining        <= remaining_n;
      wr_addr          <= wr_addr_n;
      wr_len           <= wr_len_n;
      wr_ba            <= wr_ba_n;
      wr_req           <= wr_req_n;
      frame_write_done <= fwd_n;
      frame_cnt        <= frame_cnt_n;
      load_pend        <= load_pend_n;
    end
  end

endmodule

// File: tb/tb_sdram_frame_wr_ctrl.sv
// Scoreboard bench for sdram_frame_wr_ctrl: stimulus queues the expected
// bursts of each frame, a monitor pops them as requests appear.
module tb_sdram_frame_wr_ctrl;

  localparam int FW = 600;
  localparam int BL = 256;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [8:0]  len;
  } burst_t;

  logic        clk, rst_n;
  logic        sdram_init_done, wr_load, wr_ack, wr_done;
  logic [1:0]  wr_bank;
  logic [9:0]  fifo_usedw;
  logic        wr_req, frame_write_done;
  logic [1:0]  wr_ba;
  logic [21:0] wr_addr;
  logic [8:0]  wr_len;
  logic [7:0]  frame_cnt;

  sdram_frame_wr_ctrl #(
    .FRAME_WORDS(FW), .BURST_LEN(BL),
    .ADDR_W(22), .LEN_W(9), .USED_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sdram_init_done(sdram_init_done),
    .wr_load(wr_load), .wr_bank(wr_bank),
    .fifo_usedw(fifo_usedw),
    .wr_ack(wr_ack), .wr_done(wr_done),
    .wr_req(wr_req), .wr_ba(wr_ba),
    .wr_addr(wr_addr), .wr_len(wr_len),
    .frame_write_done(frame_write_done),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_pass = 0;
  int     n_tot  = 0;
  int     mdl_cnt = 0;
  burst_t exp_q[$];
  logic [7:0] done_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int need_of(input int k);
    int left = FW - k * BL;
    return (left < BL) ? left : BL;
  endfunction

  // Model: a frame is just consecutive BL-word chunks from address 0.
  task automatic apply_load(input logic [1:0] b);
    wr_load = 1'b1;
    wr_bank = b;
    exp_q.delete();
    for (int a = 0; a < FW; a += BL) begin
      burst_t e;
      e.ba   = b;
      e.addr = 22'(a);
      e.len  = 9'((FW - a < BL) ? FW - a : BL);
      exp_q.push_back(e);
    end
    done_q.delete();
    done_q.push_back(8'(mdl_cnt + 1));
    @(negedge clk);
    wr_load = 1'b0;
    chk("fwd_clear", 64'(frame_write_done), 64'(0));
  endtask

  task automatic wait_req(input int need, input bit rnd);
    int v;
    bit ok  = 1'b1;
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (!rnd) v = 1023;
      else if ($urandom_range(0, 1) == 1) v = $urandom_range(0, 400);
      else v = $urandom_range(need - 2, need + 1);
      fifo_usedw = 10'(v);
      @(negedge clk);
      if (wr_req !== (v >= need)) ok = 1'b0;
      if (wr_req === 1'b1) got = 1'b1;
    end
    chk("req_latency", 64'({ok, got}), 64'(2'b11));
  endtask

  task automatic ack_done(input int ad, input int dd,
                          input bit inj, input logic [1:0] ib);
    repeat (ad) @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk("req_drop", 64'(wr_req), 64'(0));
    if (inj) apply_load(ib);
    repeat (dd) @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  task automatic frame_end();
    mdl_cnt++;
    chk("frame_done", 64'(frame_write_done), 64'(1));
    chk("frame_cnt", 64'(frame_cnt), 64'(8'(mdl_cnt)));
  endtask

  task automatic plain_frame(input logic [1:0] b);
    apply_load(b);
    for (int k = 0; k < 3; k++) begin
      wait_req(need_of(k), 1'b0);
      ack_done(1, 3, 1'b0, 2'd0);
    end
    frame_end();
  endtask

  // Monitor: checks every request against the scoreboard and that the
  // request fields stay put until the burst completes.
  initial begin
    logic   prev_req = 1'b0;
    logic   prev_fwd = 1'b0;
    logic   active = 1'b0;
    logic   stab_ok = 1'b1;
    burst_t cap, cur, e;
    forever begin
      @(posedge clk);
      #1;
      cur = {wr_ba, wr_addr, wr_len};
      if (!rst_n) begin
        active   = 1'b0;
        prev_req = 1'b0;
        prev_fwd = 1'b0;
        continue;
      end
      if (wr_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(cur), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("burst", 64'(cur), 64'(e));
        end
        active  = 1'b1;
        cap     = cur;
        stab_ok = 1'b1;
      end else if (active) begin
        if (!wr_req && prev_req && !wr_ack) begin
          active = 1'b0;
        end else if (wr_done) begin
          chk("burst_stable", 64'(stab_ok), 64'(1));
          active = 1'b0;
        end else if (cur !== cap) begin
          stab_ok = 1'b0;
        end
      end
      if (frame_write_done && !prev_fwd) begin
        if (done_q.size() == 0)
          chk("unexpected_done", 64'(frame_cnt), 64'(0));
        else
          chk("done_cnt", 64'(frame_cnt), 64'(done_q.pop_front()));
      end
      prev_req = wr_req;
      prev_fwd = frame_write_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    logic [1:0] b;
    rst_n = 1'b0;
    sdram_init_done = 1'b1;
    wr_load = 1'b0;
    wr_bank = 2'd0;
    fifo_usedw = 10'd1023;
    wr_ack = 1'b0;
    wr_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({wr_req, wr_ba, wr_addr, wr_len,
        frame_write_done, frame_cnt}), 64'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_req", 64'(wr_req), 64'(0));

    // Init gating, then the 600-word frame into bank 2.
    sdram_init_done = 1'b0;
    apply_load(2'd2);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (wr_req !== 1'b0) ok = 1'b0;
    end
    chk("init_gate", 64'(ok), 64'(1));
    sdram_init_done = 1'b1;
    @(negedge clk);
    chk("init_rise", 64'(wr_req), 64'(1));
    ack_done(0, 4, 1'b0, 2'd0);
    wait_req(256, 1'b0);
    ack_done(0, 4, 1'b0, 2'd0);
    wait_req(88, 1'b0);
    ack_done(0, 4, 1'b0, 2'd0);
    frame_end();

    // FIFO threshold exactly at the burst size.
    apply_load(2'd1);
    ok = 1'b1;
    for (int v = 0; v < 256; v++) begin
      fifo_usedw = 10'(v);
      @(negedge clk);
      if (wr_req !== 1'b0) ok = 1'b0;
    end
    chk("ramp_no_req", 64'(ok), 64'(1));
    fifo_usedw = 10'd256;
    @(negedge clk);
    chk("ramp_256", 64'(wr_req), 64'(1));
    ack_done(1, 3, 1'b0, 2'd0);
    wait_req(256, 1'b0);
    ack_done(1, 3, 1'b0, 2'd0);
    ok = 1'b1;
    for (int v = 80; v < 88; v++) begin
      fifo_usedw = 10'(v);
      @(negedge clk);
      if (wr_req !== 1'b0) ok = 1'b0;
    end
    chk("tail_no_req", 64'(ok), 64'(1));
    fifo_usedw = 10'd88;
    @(negedge clk);
    chk("tail_88", 64'(wr_req), 64'(1));
    ack_done(0, 2, 1'b0, 2'd0);
    frame_end();

    // Restart during the second burst of a frame.
    apply_load(2'd1);
    wait_req(256, 1'b0);
    ack_done(0, 2, 1'b0, 2'd0);
    wait_req(256, 1'b0);
    ack_done(1, 3, 1'b1, 2'd3);
    chk("abort_no_fwd", 64'(frame_write_done), 64'(0));
    chk("abort_cnt", 64'(frame_cnt), 64'(8'(mdl_cnt)));
    for (int k = 0; k < 3; k++) begin
      wait_req(need_of(k), 1'b0);
      ack_done(0, 1, 1'b0, 2'd0);
    end
    frame_end();

    // Restart while a request is pending without ack.
    apply_load(2'd0);
    wait_req(256, 1'b0);
    apply_load(2'd3);
    chk("withdraw", 64'(wr_req), 64'(0));
    for (int k = 0; k < 3; k++) begin
      wait_req(need_of(k), 1'b0);
      ack_done(0, 2, 1'b0, 2'd0);
    end
    frame_end();

    // Randomised frames: banks, FIFO levels and handshake delays.
    repeat (8) begin
      b = 2'($urandom_range(0, 3));
      apply_load(b);
      for (int k = 0; k < 3; k++) begin
        wait_req(need_of(k), 1'b1);
        ack_done($urandom_range(0, 3), $urandom_range(0, 6),
                 1'b0, 2'd0);
      end
      frame_end();
    end
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));

    // Asynchronous reset in the middle of a burst.
    apply_load(2'd2);
    wait_req(256, 1'b0);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", 64'({wr_req, wr_ba, wr_addr, wr_len,
        frame_write_done, frame_cnt}), 64'(0));
    exp_q.delete();
    done_q.delete();
    mdl_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
      if ({wr_req, wr_addr, frame_cnt, frame_write_done} !== '0)
        ok = 1'b0;
    end
    chk("stray_ignored", 64'(ok), 64'(1));
    plain_frame(2'd1);
    chk("exp_q_final", 64'(exp_q.size()), 64'(0));
    chk("done_q_final", 64'(done_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
